// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life core: controller states,
// grid index mapping and the B3/S23 cell rule.
package life_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PAUSE = 2'd1,
      RUN   = 2'd2,
      HALT  = 2'd3
   } state_t;

   function automatic int cell_idx(input int r, input int c, input int cols);
      return r * cols + c;
   endfunction

   function automatic logic next_cell(input logic alive, input logic [3:0] count);
      return (count == 4'd3) || (alive && (count == 4'd2));
   endfunction

endpackage

// File: rtl/life_engine_if.sv
// Command/status bundle between the seed/control side and the life core.
interface life_engine_if #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int CNT_W = 16
);
   logic [ROWS*COLS-1:0] seed;
   logic                 load;
   logic                 run;
   logic                 step;
   logic                 torus;
   logic [ROWS*COLS-1:0] grid_out;
   logic [CNT_W-1:0]     gen_count;
   logic                 running;
   logic                 stable;
   logic                 extinct;

   modport master (
      output seed, load, run, step, torus,
      input  grid_out, gen_count, running, stable, extinct
   );

   modport slave (
      input  seed, load, run, step, torus,
      output grid_out, gen_count, running, stable, extinct
   );
endinterface

// File: rtl/life_ctrl.sv
// Sequencer for the life core: run/step/halt FSM, generation period counter
// and saturating generation counter. Emits a one-cycle gen_en per generation.
//
//   state | meaning
//   IDLE  | no grid loaded yet; run/step ignored
//   PAUSE | grid held; step advances one generation, run starts free-run
//   RUN   | one generation every PERIOD cycles while run is high
//   HALT  | frozen after a stable/extinct generation; only load exits
module life_ctrl
   import life_pkg::*;
#(
   parameter int PERIOD    = 1,
   parameter int CNT_W     = 16,
   parameter int AUTO_HALT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             run,
   input  logic             step,
   input  logic             halt_cond,
   output logic             gen_en,
   output logic             running,
   output logic [CNT_W-1:0] gen_count
);
   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);

   state_t           state_q, state_d;
   logic [PW-1:0]    per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0] gen_cnt_q, gen_cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         per_cnt_q <= '0;
         gen_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         per_cnt_q <= per_cnt_d;
         gen_cnt_q <= gen_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      per_cnt_d = per_cnt_q;
      gen_cnt_d = gen_cnt_q;
      gen_en    = 1'b0;
      if (load) begin
         state_d   = PAUSE;
         per_cnt_d = '0;
         gen_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: ;
            PAUSE: begin
               if (run) begin
                  state_d   = RUN;
                  per_cnt_d = '0;
               end else if (step) begin
                  gen_en = 1'b1;
               end
            end
            RUN: begin
               if (!run) begin
                  state_d   = PAUSE;
                  per_cnt_d = '0;
               end else if (per_cnt_q == PER_LAST) begin
                  gen_en    = 1'b1;
                  per_cnt_d = '0;
               end else begin
                  per_cnt_d = per_cnt_q + PW'(1);
               end
            end
            HALT: ;
            default: state_d = IDLE;
         endcase
         // the generation edge itself decides whether we freeze
         if (gen_en && (AUTO_HALT != 0) && halt_cond) state_d = HALT;
         if (gen_en && (gen_cnt_q != '1)) gen_cnt_d = gen_cnt_q + CNT_W'(1);
      end
   end

   assign running   = (state_q == RUN);
   assign gen_count = gen_cnt_q;

endmodule

// File: rtl/life_engine.sv
// Parametrised Game of Life core: grid register, per-cell neighbour count and
// B3/S23 rule, with toroidal or dead-edge boundaries.
module life_engine
   import life_pkg::*;
#(
   parameter int ROWS      = 8,
   parameter int COLS      = 8,
   parameter int PERIOD    = 1,
   parameter int CNT_W     = 16,
   parameter int AUTO_HALT = 1
) (
   input logic          clk,
   input logic          reset,
   life_engine_if.slave bus
);
   localparam int N = ROWS * COLS;

   logic [N-1:0] grid_q, grid_d, next_grid;
   logic         stable_q, stable_d;
   logic         extinct_q, extinct_d;
   logic         gen_en, halt_cond;

   life_ctrl #(
      .PERIOD    (PERIOD),
      .CNT_W     (CNT_W),
      .AUTO_HALT (AUTO_HALT)
   ) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .load      (bus.load),
      .run       (bus.run),
      .step      (bus.step),
      .halt_cond (halt_cond),
      .gen_en    (gen_en),
      .running   (bus.running),
      .gen_count (bus.gen_count)
   );

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         localparam int RN = (r + ROWS - 1) % ROWS;
         localparam int RS = (r + 1) % ROWS;
         localparam int CW = (c + COLS - 1) % COLS;
         localparam int CE = (c + 1) % COLS;
         localparam logic IN_N = (r > 0);
         localparam logic IN_S = (r < ROWS - 1);
         localparam logic IN_W = (c > 0);
         localparam logic IN_E = (c < COLS - 1);

         logic [7:0] nb, nb_live;
         logic [3:0] n;

         // order: NW N NE W E SW S SE; wrapped indices are masked off at dead edges
         assign nb = {grid_q[cell_idx(RN, CW, COLS)], grid_q[cell_idx(RN, c, COLS)],
                      grid_q[cell_idx(RN, CE, COLS)], grid_q[cell_idx(r, CW, COLS)],
                      grid_q[cell_idx(r, CE, COLS)],  grid_q[cell_idx(RS, CW, COLS)],
                      grid_q[cell_idx(RS, c, COLS)],  grid_q[cell_idx(RS, CE, COLS)]};
         assign nb_live = nb & (bus.torus ? 8'hFF :
                          {IN_N & IN_W, IN_N, IN_N & IN_E, IN_W,
                           IN_E, IN_S & IN_W, IN_S, IN_S & IN_E});

         always_comb begin
            n = '0;
            for (int i = 0; i < 8; i++) n = n + 4'(nb_live[i]);
         end

         assign next_grid[cell_idx(r, c, COLS)] = next_cell(grid_q[cell_idx(r, c, COLS)], n);
      end
   end

   assign halt_cond = (next_grid == grid_q) || (next_grid == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grid_q    <= '0;
         stable_q  <= 1'b0;
         extinct_q <= 1'b1;
      end else begin
         grid_q    <= grid_d;
         stable_q  <= stable_d;
         extinct_q <= extinct_d;
      end
   end

   always_comb begin
      grid_d    = grid_q;
      stable_d  = stable_q;
      extinct_d = extinct_q;
      if (bus.load) begin
         grid_d    = bus.seed;
         stable_d  = 1'b0;
         extinct_d = (bus.seed == '0);
      end else if (gen_en) begin
         grid_d    = next_grid;
         stable_d  = (next_grid == grid_q);
         extinct_d = (next_grid == '0);
      end
   end

   assign bus.grid_out = grid_q;
   assign bus.stable   = stable_q;
   assign bus.extinct  = extinct_q;

endmodule

// File: doc/life_engine.md
Name: life_engine

Overview:
- Parametrised Game of Life core; the next-generation replacement for the fixed 8x8 grid engine.
- Holds a ROWS x COLS cell grid, loads it from a seed bus fed by the LFSR, and evolves it under B3/S23 rules.
- Adds toroidal or dead-edge boundary mode, a programmable generation period and single-step.
- Also adds a generation counter and stable/extinct detection with optional auto-halt.
- Sits between the seed LFSR and the display mux; grid_out drives the display directly.

Parameters:
- ROWS, 8, number of grid rows (>=3)
- COLS, 8, number of grid columns (>=3)
- PERIOD, 1, clock cycles per generation while running (>=1)
- CNT_W, 16, generation counter width
- AUTO_HALT, 1, when 1, entering a stable or extinct condition forces the HALT state

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- seed  input  ROWS*COLS  initial grid pattern
- load  input  1  pulse: copy seed into the grid
- run  input  1  level: free-run evolution
- step  input  1  pulse: advance exactly one generation while paused
- torus  input  1  1 = edges wrap; 0 = out-of-grid neighbours count as dead
- grid_out  output  ROWS*COLS  current grid; bit r*COLS+c is cell (r,c); r=0/c=0 at bit 0
- gen_count  output  CNT_W  generations since the last load; saturates at all-ones
- running  output  1  high in the RUN state
- stable  output  1  last generation produced a grid identical to its predecessor
- extinct  output  1  grid is all zero

Behaviour:
- Reset (asynchronous):
  - grid=0, gen_count=0, stable=0, extinct=1, period counter=0, state=IDLE.
- States: IDLE, PAUSE, RUN, HALT.
- Global priority: reset > load > run/step.
- load, from any state:
  - next edge: grid<=seed, gen_count<=0, stable<=0, extinct<=(seed==0), period counter<=0.
  - State goes to PAUSE, even mid-RUN.
  - An evolution that would have occurred on that edge is dropped.
- IDLE: waits for load; run and step are ignored.
- PAUSE:
  - run=1 -> RUN, period counter cleared.
  - step=1 with run=0 -> one generation on the next edge; state stays PAUSE.
  - step and run both high: run wins, and no extra generation is taken.
- RUN:
  - The period counter counts 0..PERIOD-1; a generation is applied on the edge where the counter equals PERIOD-1, then the counter wraps to 0.
  - With PERIOD=1, a generation occurs every cycle; the first generation lands on the first edge after entering RUN.
  - run=0 -> PAUSE; no generation on that edge.
- HALT:
  - Entered from RUN or PAUSE on the edge that applies a generation producing stable or extinct, only when AUTO_HALT=1.
  - Only load or reset exits HALT.
- Generation (all cells in parallel):
  - n = live neighbour count, 0..8.
  - Next cell = 1 if n==3, or if cell==1 and n==2; otherwise 0.
  - torus=1: neighbour indices taken modulo ROWS/COLS.
  - torus=0: neighbours outside the grid count as 0.
  - torus is sampled combinationally at the generation edge; changing it mid-run affects the next generation only.
- Flags, updated on each generation edge:
  - gen_count increments by 1, holding once saturated.
  - stable<=(next==grid).
  - extinct<=(next==0).
- Latency:
  - grid_out is a direct register output.
  - After load, seed is visible on grid_out the next cycle.
  - After a step pulse, the new generation is visible the next cycle.

Decomposition:
- Package life_pkg:
  - state enum (IDLE, PAUSE, RUN, HALT).
  - Function cell_idx(r,c).
  - B3/S23 rule function next_cell(alive, count).
- Sub-module life_ctrl:
  - Holds the FSM, the period counter and the gen_count saturation.
  - Emits a one-cycle gen_en to the datapath in life_engine, which holds the grid register and the neighbour/rule generate loop.

Test Plan:
- 8x8, torus=0, blinker:
  - load seed=64'h0000_0000_1C00_0000, pulse step -> grid_out=64'h0000_0008_0808_0000, gen_count=1.
  - Second step -> 64'h0000_0000_1C00_0000, stable=0.
- Single cell:
  - load seed=64'h1, step -> grid_out=0, extinct=1, state HALT.
  - A further step or run leaves gen_count=1.
- Block still life, torus=0:
  - seed=64'h303, run=1 -> after 1 generation grid_out=64'h303, stable=1, running=0 (HALT).
- Torus wrap:
  - seed=64'h8000_0000_0000_0001 (corners (7,7) and (0,0)), torus=1 vs torus=0.
  - Both cases yield extinct after one step; repeat with an L-tromino across the corner (bits 0,7,56) -> torus=1 births bit 63; torus=0 yields all zero.
- PERIOD=4, blinker under run=1:
  - grid changes exactly every 4 cycles.
  - Deassert run mid-period -> no change.
  - load mid-RUN -> seed on grid_out next cycle, gen_count=0, state PAUSE.
- CNT_W=4, blinker with AUTO_HALT=0, run for 20 generations:
  - gen_count stops at 15.
  - Asserting reset mid-run -> grid_out=0, gen_count=0, extinct=1 immediately, without waiting for a clock edge.
